// File: rtl/simple_computer_mc.sv
// Multi-cycle 4-register computer: host loads IMEM while halted, pulses START, observes via debug port.
// Latency 2 cycles (NOP/ST/BRZ/JMP/HLT) or 3 (register writes); no backpressure, host polls HALTED.

module simple_computer_mc #(
  parameter int DW    = 4,
  parameter int PC_W  = 4,
  parameter int DM_AW = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            PROG_WE,
  input  logic [PC_W-1:0] PROG_ADDR,
  input  logic [15:0]     PROG_DATA,
  input  logic [1:0]      DBG_SEL,
  output logic [DW-1:0]   DBG_DATA,
  output logic [PC_W-1:0] PC,
  output logic [15:0]     IR,
  output logic [1:0]      STATE,
  output logic            ZFLAG,
  output logic            CFLAG,
  output logic            HALTED
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_WB    = 2'b11
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7, OP_ADI = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9, OP_LD  = 4'hA, OP_ST  = 4'hB, OP_BRZ = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD, OP_SHR = 4'hE, OP_HLT = 4'hF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [DW-1:0]   res_q, res_d;
  logic            z_q, z_d, c_q, c_d;
  logic [DW-1:0]   rf_q [4];
  logic            rf_we;
  logic [DW-1:0]   rf_wdat;
  logic            imem_we, dm_we;
  logic [15:0]     imem [2**PC_W];
  logic [DW-1:0]   dmem [2**DM_AW];
  logic [DW-1:0]   ld_q;

  logic [3:0]      op;
  logic [1:0]      da, aa, ba;
  logic [5:0]      imm;
  logic [21:0]     imm_ext;
  logic            unused_imm;
  logic [DW-1:0]   opa, opb, k, alu_r;
  logic            alu_c, flag_op;
  logic [PC_W-1:0] tgt;

  assign op         = ir_q[15:12];
  assign da         = ir_q[11:10];
  assign aa         = ir_q[9:8];
  assign ba         = ir_q[7:6];
  assign imm        = ir_q[5:0];
  assign imm_ext    = {16'b0, imm};
  assign k          = imm_ext[DW-1:0];
  assign tgt        = imm_ext[PC_W-1:0];
  assign unused_imm = ^imm_ext;
  assign opa        = rf_q[aa];
  assign opb        = rf_q[ba];

  always_comb begin
    alu_r   = opa;
    alu_c   = 1'b0;
    flag_op = 1'b1;
    case (op)
      OP_ADD:  {alu_c, alu_r} = {1'b0, opa} + {1'b0, opb};
      OP_SUB:  begin alu_r = opa - opb; alu_c = (opa < opb); end
      OP_AND:  alu_r = opa & opb;
      OP_OR:   alu_r = opa | opb;
      OP_XOR:  alu_r = opa ^ opb;
      OP_NOT:  alu_r = ~opa;
      OP_ADI:  {alu_c, alu_r} = {1'b0, opa} + {1'b0, k};
      OP_SHR:  begin alu_r = opa >> 1; alu_c = opa[0]; end
      OP_LDI:  begin alu_r = k; flag_op = 1'b0; end
      // MOV passes A through; LD/NOP/ST/branches/HLT never touch flags
      default: flag_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    rf_we   = 1'b0;
    rf_wdat = res_q;
    imem_we = 1'b0;
    dm_we   = 1'b0;
    case (state_q)
      S_HALT: begin
        imem_we = PROG_WE;
        if (START) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = imem[pc_q];
        pc_d    = pc_q + PC_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = alu_r;
        if (flag_op) begin
          z_d = (alu_r == '0);
          c_d = alu_c;
        end
        case (op)
          OP_NOP:  state_d = S_FETCH;
          OP_ST:   begin dm_we = 1'b1; state_d = S_FETCH; end
          OP_BRZ:  begin if (z_q) pc_d = tgt; state_d = S_FETCH; end
          OP_JMP:  begin pc_d = tgt; state_d = S_FETCH; end
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_WB;
        endcase
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wdat = (op == OP_LD) ? ld_q : res_q;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_HALT;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q  <= '0;
      ir_q  <= '0;
      res_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      res_q <= res_d;
      z_q   <= z_d;
      c_q   <= c_d;
      if (rf_we) rf_q[da] <= rf_wdat;
    end
  end

  // Memories hold contents across reset; write enables are gated by the reset-cleared state.
  always_ff @(posedge CLK) begin
    if (imem_we) imem[PROG_ADDR] <= PROG_DATA;
    if (dm_we)   dmem[opa[DM_AW-1:0]] <= opb;
    ld_q <= dmem[opa[DM_AW-1:0]];
  end

  assign DBG_DATA = rf_q[DBG_SEL];
  assign PC       = pc_q;
  assign IR       = ir_q;
  assign STATE    = state_q;
  assign ZFLAG    = z_q;
  assign CFLAG    = c_q;
  assign HALTED   = (state_q == S_HALT);

endmodule

// File: doc/simple_computer_mc.md
Name: simple_computer_mc

Overview:
Parametrised multi-cycle successor of the single-cycle simple computer. It contains a program counter, a 16-bit instruction register, a 4-entry register file, an ALU with Z/C flags, a writable instruction memory and a data memory. Execution is driven by a FETCH/EXEC/WB/HALT state machine. A host loads the program through a write port, pulses START, and observes results through a debug port and the HALTED flag.

Parameters:
DW, 4, data/register width in bits (4..16)
PC_W, 4, PC width; instruction memory depth = 2^PC_W words of 16 bits
DM_AW, 4, data-memory address width (≤ DW); address = A[DM_AW-1:0]

Ports:
CLK  in  1  rising-edge clock
RESET  in  1  asynchronous, active-high reset
START  in  1  in HALT: begin execution at PC=0; ignored in other states
PROG_WE  in  1  instruction-memory write enable; honoured only in HALT
PROG_ADDR  in  PC_W  instruction-memory write address
PROG_DATA  in  16  instruction word to write
DBG_SEL  in  2  register selected for DBG_DATA
DBG_DATA  out  DW  combinational read of R[DBG_SEL]
PC  out  PC_W  current program counter
IR  out  16  current instruction register
STATE  out  2  00 HALT, 01 FETCH, 10 EXEC, 11 WB
ZFLAG  out  1  zero flag of the last ALU op
CFLAG  out  1  carry/borrow flag of the last ADD/SUB/ADI
HALTED  out  1  high when STATE==HALT

Behaviour:
- Instruction format: op[15:12], DA[11:10], AA[9:8], BA[7:6], IMM[5:0]. K = IMM zero-extended or truncated to DW.
- Opcodes:
  - 0 NOP
  - 1 MOV: R[DA]=A
  - 2 ADD: A+B
  - 3 SUB: A-B
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOT A
  - 8 ADI: A+K
  - 9 LDI: R[DA]=K
  - A LD: R[DA]=M[A]
  - B ST: M[A]=B
  - C BRZ: if Z, PC=IMM[PC_W-1:0]
  - D JMP: PC=IMM[PC_W-1:0]
  - E SHR: R[DA]=A>>1, C=A[0]
  - F HLT
  - Here A=R[AA] and B=R[BA].
- Reset (async): STATE=HALT, PC=0, IR=0, all registers 0, Z=0, C=0. Memory contents are not reset.
- HALT:
  - PROG_WE writes IMEM[PROG_ADDR]=PROG_DATA at the clock edge.
  - START (sampled high) → FETCH with PC=0.
  - If PROG_WE and START are high in the same cycle, the write completes and execution starts in the same edge.
- FETCH: IR <= IMEM[PC]; PC <= PC+1 (wraps modulo 2^PC_W) → EXEC.
- EXEC:
  - ALU result latched; flags updated only by ALU ops 2–8 and E. MOV, LDI and LD leave flags unchanged.
  - Z = (result==0). C = carry out for ADD/ADI; C = borrow (A<B) for SUB; C = A[0] for SHR; C=0 for logic ops.
  - ST writes M[A[DM_AW-1:0]] at this edge.
  - BRZ/JMP load PC at this edge.
  - LD issues a synchronous DMEM read.
  - Transitions: HLT → HALT (PC keeps the value already incremented). NOP/ST/BRZ/JMP → FETCH. All others → WB.
- WB: R[DA] <= latched result, or DMEM read data for LD → FETCH.
- Latency:
  - 2 cycles: NOP/ST/BRZ/JMP/HLT
  - 3 cycles: register-writing instructions
  - START-to-first-FETCH edge: 1 cycle
- Arithmetic is modulo 2^DW. DA may equal AA or BA; operands are read before the write-back.
- PROG_WE outside HALT is ignored, so the running program is never corrupted.
- START outside HALT is ignored.
- RESET mid-instruction aborts the instruction: no register or memory write occurs after assertion.
- PC wrap: fetching at 2^PC_W-1 continues at 0.

Test Plan:
- DW=4: load program LDI R1,5; LDI R2,3; ADD R3,R1,R2; HLT; pulse START → HALTED after 3+3+3+2=11 cycles; R3=8, Z=0, C=0, PC=4.
- ADD with carry: R1=0xF, R2=0x1 → R3=0, Z=1, C=1. Then SUB R0,R2,R1 (1-15) → R0=0x2, C=1.
- LDI R1,9; LDI R0,6; ST [R0],R1; LD R2,[R0]; HLT → M[6]=9, R2=9.
- Branch loop: LDI R1,3; loop: ADI R1,R1,0xF (i.e. -1); BRZ end; JMP loop; end: HLT → terminates with R1=0 and HALTED=1; cycle count matches the per-instruction latencies above.
- Assert RESET during WB of ADD → R[DA] unchanged (0), STATE=HALT, PC=0 immediately. PROG_WE pulsed while running → IMEM unchanged on readback.
- DW=8, PC_W=5: LDI R1,0x3F; ADI R1,R1,0x3F → R1=0x7E, C=0. Fetch at PC=31 → next PC=0.
